// File: rtl/dut_sample_pkg.sv
// Shared state encoding, default parameter values and width helpers for the
// DUT-side sample packer.
package dut_sample_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_COLLECT = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int unsigned DEF_W          = 64;
  localparam int unsigned DEF_OUTPUT_W   = 4;
  localparam int unsigned DEF_COEFF_W    = 23;
  localparam int unsigned DEF_N_COEFF    = 256;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  function automatic int unsigned bundle_w(input int unsigned lanes, input int unsigned coeff_w);
    return lanes * coeff_w;
  endfunction

  // A single-lane build still needs a one-bit index register.
  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n_coeff);
    return $clog2(n_coeff + 1);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; depth must be a power of 2.
module sample_fifo #(
  parameter int unsigned WIDTH = 92,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
            (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    rd_en = pop & !empty;
    wr_en = push & (!full | rd_en);
    rdata = mem[rd_ptr[PTR_W-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/dut_sample_packer.sv
// Accepts one host seed per run, forwards it to the sampler core, packs the
// returned coefficient stream into lane bundles and queues them for the host.
module dut_sample_packer
  import dut_sample_pkg::*;
#(
  parameter int unsigned pW          = DEF_W,
  parameter int unsigned pOUTPUT_W   = DEF_OUTPUT_W,
  parameter int unsigned pCOEFF_W    = DEF_COEFF_W,
  parameter int unsigned pN_COEFF    = DEF_N_COEFF,
  parameter int unsigned pFIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                            crypto_clk,
  input  logic                            reset_n,
  input  logic                            i_clear,
  input  logic [pW-1:0]                   i_di,
  input  logic                            i_valid,
  output logic                            o_ready,
  output logic [pW-1:0]                   o_seed,
  output logic                            o_seed_valid,
  input  logic                            i_seed_ready,
  input  logic [pCOEFF_W-1:0]             i_coeff,
  input  logic                            i_coeff_valid,
  output logic                            o_coeff_ready,
  output logic [pOUTPUT_W*pCOEFF_W-1:0]   o_samples,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int unsigned BUNDLE_W   = bundle_w(pOUTPUT_W, pCOEFF_W);
  localparam int unsigned LANE_IDX_W = lane_idx_w(pOUTPUT_W);
  localparam int unsigned CNT_W      = cnt_w(pN_COEFF);
  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(pOUTPUT_W - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(pN_COEFF - 1);

  state_t                  state;
  state_t                  state_next;
  logic                    arm;
  logic [LANE_IDX_W-1:0]   lane_idx;
  logic [CNT_W-1:0]        coeff_cnt;
  logic [BUNDLE_W-1:0]     lanes;
  logic [BUNDLE_W-1:0]     bundle_next;
  logic [BUNDLE_W-1:0]     fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    seed_xfer;
  logic                    coeff_xfer;
  logic                    last_lane;
  logic                    last_coeff;

  // Any pushing transfer (last lane or final partial bundle) needs FIFO room,
  // so the final coefficient is stalled on a full FIFO just like a last lane.
  always_comb begin
    pop           = !fifo_empty & i_ready;
    last_lane     = (lane_idx == LAST_LANE);
    last_coeff    = (coeff_cnt == LAST_CNT);
    o_ready       = (state == ST_SEED) & arm & !o_seed_valid & !i_clear;
    seed_xfer     = i_valid & o_ready;
    o_coeff_ready = (state == ST_COLLECT) & !i_clear &
                    (!(last_lane | last_coeff) | !fifo_full | pop);
    coeff_xfer    = i_coeff_valid & o_coeff_ready;
    push          = coeff_xfer & (last_lane | last_coeff);
    bundle_next   = lanes;
    bundle_next[lane_idx*pCOEFF_W +: pCOEFF_W] = i_coeff;
    o_valid       = !fifo_empty;
    o_samples     = fifo_empty ? '0 : fifo_head;
  end

  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    unique case (state)
      ST_IDLE:    state_next = ST_IDLE;
      ST_SEED: begin
        o_busy = 1'b1;
        if (o_seed_valid && i_seed_ready) state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        o_busy = 1'b1;
        if (coeff_xfer && last_coeff) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        if (fifo_empty) state_next = ST_DONE;
      end
      ST_DONE:    o_done = 1'b1;
      default:    state_next = ST_IDLE;
    endcase
    if (i_clear) state_next = ST_SEED;
  end

  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) begin
      o_seed       <= '0;
      o_seed_valid <= 1'b0;
      arm          <= 1'b0;
    end else if (i_clear) begin
      o_seed_valid <= 1'b0;
      arm          <= 1'b1;
    end else if (seed_xfer) begin
      o_seed       <= i_di;
      o_seed_valid <= 1'b1;
      arm          <= 1'b0;
    end else if (o_seed_valid && i_seed_ready) begin
      o_seed_valid <= 1'b0;
    end
  end

  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) begin
      lanes     <= '0;
      lane_idx  <= '0;
      coeff_cnt <= '0;
    end else if (i_clear) begin
      lanes     <= '0;
      lane_idx  <= '0;
      coeff_cnt <= '0;
    end else if (coeff_xfer) begin
      coeff_cnt <= coeff_cnt + 1'b1;
      if (push) begin
        lanes    <= '0;
        lane_idx <= '0;
      end else begin
        lanes    <= bundle_next;
        lane_idx <= lane_idx + 1'b1;
      end
    end
  end

  sample_fifo #(
    .WIDTH (BUNDLE_W),
    .DEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .clk   (crypto_clk),
    .rst_n (reset_n),
    .flush (i_clear),
    .push  (push),
    .wdata (bundle_next),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_dut_sample_packer.sv
// Directed bench for dut_sample_packer built with a 22-coefficient run so full
// bundles, a trailing partial bundle and FIFO backpressure all fit in one run.
module tb_dut_sample_packer;

  localparam int unsigned W     = 64;
  localparam int unsigned LANES = 4;
  localparam int unsigned CW    = 23;
  localparam int unsigned NC    = 22;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BW    = LANES * CW;

  logic          crypto_clk;
  logic          reset_n;
  logic          i_clear;
  logic [W-1:0]  i_di;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  o_seed;
  logic          o_seed_valid;
  logic          i_seed_ready;
  logic [CW-1:0] i_coeff;
  logic          i_coeff_valid;
  logic          o_coeff_ready;
  logic [BW-1:0] o_samples;
  logic          o_valid;
  logic          i_ready;
  logic          o_busy;
  logic          o_done;

  dut_sample_packer #(
    .pW          (W),
    .pOUTPUT_W   (LANES),
    .pCOEFF_W    (CW),
    .pN_COEFF    (NC),
    .pFIFO_DEPTH (DEPTH)
  ) dut (
    .crypto_clk    (crypto_clk),
    .reset_n       (reset_n),
    .i_clear       (i_clear),
    .i_di          (i_di),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_seed        (o_seed),
    .o_seed_valid  (o_seed_valid),
    .i_seed_ready  (i_seed_ready),
    .i_coeff       (i_coeff),
    .i_coeff_valid (i_coeff_valid),
    .o_coeff_ready (o_coeff_ready),
    .o_samples     (o_samples),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial crypto_clk = 1'b0;
  always #5 crypto_clk = ~crypto_clk;

  typedef struct {
    logic [3:0][CW-1:0] c;
    int                 n;
    logic [BW-1:0]      exp;
  } vec_t;

  vec_t tbl [6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge crypto_clk);
    #1;
  endtask

  function automatic vec_t mk(input int n, input int a, input int b, input int c, input int d,
                              input logic [BW-1:0] e);
    vec_t v;
    v.c[0] = CW'(a);
    v.c[1] = CW'(b);
    v.c[2] = CW'(c);
    v.c[3] = CW'(d);
    v.n    = n;
    v.exp  = e;
    return v;
  endfunction

  // Bundle nb of a run whose coefficients are 1..NC; lanes past NC are zero.
  function automatic logic [BW-1:0] exp_seq(input int nb);
    logic [BW-1:0] r;
    int            v;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      v = 4 * nb + 1 + l;
      if (v <= NC) r[l*CW +: CW] = CW'(v);
    end
    return r;
  endfunction

  task automatic do_seed(input logic [W-1:0] s);
    i_clear = 1'b1;
    cyc();
    i_clear      = 1'b0;
    i_di         = s;
    i_valid      = 1'b1;
    i_seed_ready = 1'b1;
    cyc();
    cyc();
    i_valid      = 1'b0;
    i_seed_ready = 1'b0;
    #1;
    chk("seed_value", 128'(o_seed), 128'(s));
    chk("seed_to_collect", 128'(o_coeff_ready), 128'(1));
  endtask

  task automatic run_table();
    for (int r = 0; r < 6; r++) begin
      for (int l = 0; l < tbl[r].n; l++) begin
        i_coeff_valid = 1'b1;
        i_coeff       = tbl[r].c[l];
        #1;
        chk("tbl_coeff_ready", 128'(o_coeff_ready), 128'(1));
        chk("tbl_valid_early", 128'(o_valid), 128'(0));
        cyc();
      end
      i_coeff_valid = 1'b0;
      i_ready       = 1'b1;
      #1;
      chk("tbl_valid", 128'(o_valid), 128'(1));
      chk("tbl_bundle", 128'(o_samples), 128'(tbl[r].exp));
      cyc();
      i_ready = 1'b0;
    end
    for (int t = 0; t < 8 && !o_done; t++) cyc();
    chk("tbl_done", 128'(o_done), 128'(1));
    chk("tbl_done_busy", 128'(o_busy), 128'(0));
    chk("tbl_done_valid", 128'(o_valid), 128'(0));
    i_coeff_valid = 1'b1;
    #1;
    chk("done_coeff_ready", 128'(o_coeff_ready), 128'(0));
    i_coeff_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the test finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int val;
    int acc;
    int nb;

    tbl[0] = mk(4, 1, 2, 3, 4, {23'd4, 23'd3, 23'd2, 23'd1});
    tbl[1] = mk(4, 5, 6, 7, 8, {23'd8, 23'd7, 23'd6, 23'd5});
    tbl[2] = mk(4, 'h7FFFFF, 0, 'h2AAAAA, 'h555555,
                {23'h555555, 23'h2AAAAA, 23'h000000, 23'h7FFFFF});
    tbl[3] = mk(4, 1, 'h400000, 'h123456, 'h654321,
                {23'h654321, 23'h123456, 23'h400000, 23'h000001});
    tbl[4] = mk(4, 9, 10, 11, 12, {23'd12, 23'd11, 23'd10, 23'd9});
    tbl[5] = mk(2, 21, 22, 0, 0, {23'd0, 23'd0, 23'd22, 23'd21});

    reset_n       = 1'b0;
    i_clear       = 1'b0;
    i_di          = '0;
    i_valid       = 1'b0;
    i_seed_ready  = 1'b0;
    i_coeff       = '0;
    i_coeff_valid = 1'b0;
    i_ready       = 1'b0;
    #12;
    chk("rst_ready", 128'(o_ready), 128'(0));
    chk("rst_seed", 128'(o_seed), 128'(0));
    chk("rst_seed_valid", 128'(o_seed_valid), 128'(0));
    chk("rst_coeff_ready", 128'(o_coeff_ready), 128'(0));
    chk("rst_samples", 128'(o_samples), 128'(0));
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_done", 128'(o_done), 128'(0));
    reset_n = 1'b1;
    i_valid = 1'b1;
    cyc();
    cyc();
    #1;
    chk("idle_ready", 128'(o_ready), 128'(0));
    chk("idle_busy", 128'(o_busy), 128'(0));
    i_valid = 1'b0;

    // Seed handshake with VALID held high across the whole run.
    i_clear = 1'b1;
    #1;
    chk("clear_idle_coeff_ready", 128'(o_coeff_ready), 128'(0));
    cyc();
    i_clear      = 1'b0;
    i_di         = 64'h0123_4567_89AB_CDEF;
    i_valid      = 1'b1;
    i_seed_ready = 1'b0;
    #1;
    chk("seed_ready", 128'(o_ready), 128'(1));
    chk("seed_busy", 128'(o_busy), 128'(1));
    chk("seed_valid_pre", 128'(o_seed_valid), 128'(0));
    cyc();
    chk("seed_valid", 128'(o_seed_valid), 128'(1));
    chk("seed_word", 128'(o_seed), 128'(64'h0123_4567_89AB_CDEF));
    chk("seed_ready_after", 128'(o_ready), 128'(0));
    i_di = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    cyc();
    chk("seed_hold", 128'(o_seed), 128'(64'h0123_4567_89AB_CDEF));
    chk("seed_hold_valid", 128'(o_seed_valid), 128'(1));
    i_seed_ready = 1'b1;
    cyc();
    chk("seed_accepted", 128'(o_seed_valid), 128'(0));
    chk("seed_no_rearm", 128'(o_ready), 128'(0));
    chk("collect_ready", 128'(o_coeff_ready), 128'(1));
    i_seed_ready = 1'b0;
    cyc();
    cyc();
    chk("seed_single", 128'(o_seed_valid), 128'(0));
    i_valid = 1'b0;

    // Clear in the middle of COLLECT with a queued bundle and a coincident transfer.
    for (int k = 0; k < 5; k++) begin
      i_coeff_valid = 1'b1;
      i_coeff       = CW'(100 + k);
      #1;
      chk("pre_clear_ready", 128'(o_coeff_ready), 128'(1));
      cyc();
    end
    i_clear = 1'b1;
    i_coeff = CW'(105);
    #1;
    chk("clear_coeff_ready", 128'(o_coeff_ready), 128'(0));
    chk("pre_clear_valid", 128'(o_valid), 128'(1));
    cyc();
    i_clear       = 1'b0;
    i_coeff_valid = 1'b0;
    #1;
    chk("clear_flush_valid", 128'(o_valid), 128'(0));
    chk("clear_seed_ready", 128'(o_ready), 128'(1));
    chk("clear_busy", 128'(o_busy), 128'(1));
    chk("clear_seed_valid", 128'(o_seed_valid), 128'(0));

    // Full and partial bundles from the vector table.
    do_seed(64'hA5A5_0000_1111_2222);
    run_table();

    // Backpressure: FIFO of four bundles plus three lanes, then full drain.
    do_seed(64'h0000_0000_0000_0042);
    i_ready = 1'b0;
    val     = 1;
    acc     = 0;
    for (int t = 0; t < 30; t++) begin
      i_coeff_valid = 1'b1;
      i_coeff       = CW'(val);
      #1;
      if (o_coeff_ready) begin
        acc++;
        val++;
      end
      cyc();
    end
    #1;
    chk("bp_accepted", 128'(acc), 128'(19));
    chk("bp_stalled", 128'(o_coeff_ready), 128'(0));
    chk("bp_head", 128'(o_samples), 128'({23'd4, 23'd3, 23'd2, 23'd1}));
    i_ready = 1'b1;
    nb      = 0;
    for (int t = 0; t < 200 && !o_done; t++) begin
      i_coeff_valid = (val <= NC);
      i_coeff       = CW'(val);
      #1;
      if (o_valid) begin
        chk("bp_bundle", 128'(o_samples), 128'(exp_seq(nb)));
        nb++;
      end
      if (i_coeff_valid && o_coeff_ready) val++;
      cyc();
    end
    i_coeff_valid = 1'b0;
    i_ready       = 1'b0;
    chk("bp_bundles", 128'(nb), 128'(6));
    chk("bp_all_coeffs", 128'(val), 128'(NC + 1));
    chk("bp_done", 128'(o_done), 128'(1));

    // Asynchronous reset while DRAIN still holds three bundles.
    do_seed(64'h0000_0000_0000_0077);
    val = 1;
    for (int t = 0; t < 60 && val <= NC; t++) begin
      i_coeff_valid = 1'b1;
      i_coeff       = CW'(val);
      i_ready       = (val <= 16);
      #1;
      if (o_coeff_ready) val++;
      cyc();
    end
    i_coeff_valid = 1'b0;
    i_ready       = 1'b0;
    #1;
    chk("drain_busy", 128'(o_busy), 128'(1));
    chk("drain_done", 128'(o_done), 128'(0));
    chk("drain_valid", 128'(o_valid), 128'(1));
    chk("drain_head", 128'(o_samples), 128'({23'd16, 23'd15, 23'd14, 23'd13}));
    chk("drain_coeff_ready", 128'(o_coeff_ready), 128'(0));
    #2;
    reset_n = 1'b0;
    i_valid = 1'b1;
    #1;
    chk("arst_ready", 128'(o_ready), 128'(0));
    chk("arst_seed", 128'(o_seed), 128'(0));
    chk("arst_seed_valid", 128'(o_seed_valid), 128'(0));
    chk("arst_coeff_ready", 128'(o_coeff_ready), 128'(0));
    chk("arst_samples", 128'(o_samples), 128'(0));
    chk("arst_valid", 128'(o_valid), 128'(0));
    chk("arst_busy", 128'(o_busy), 128'(0));
    chk("arst_done", 128'(o_done), 128'(0));
    #2;
    reset_n = 1'b1;
    cyc();
    cyc();
    chk("post_rst_busy", 128'(o_busy), 128'(0));
    chk("post_rst_done", 128'(o_done), 128'(0));
    chk("post_rst_ready", 128'(o_ready), 128'(0));
    chk("post_rst_valid", 128'(o_valid), 128'(0));
    i_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
